// File: rtl/instr_fetch_unit_pkg.sv
// Core definitions shared by the fetch unit, the main decoder and the verification model.
// Holds the fetch FSM encoding, the reset/NOP defaults and the MIPS opcode constants.
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    StBoot = 2'd0,
    StReq  = 2'd1,
    StHold = 2'd2
  } fetch_state_e;

  localparam logic [31:0] ResetPc  = 32'h0000_0000;
  localparam logic [31:0] NopInstr = 32'h0000_0000;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;

endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection: jump over taken branch over sequential.
// All arithmetic wraps modulo 2^32.
module next_pc_logic (
  input  logic [31:0] pc,
  input  logic        Jump,
  input  logic        Branch,
  input  logic        Zero,
  input  logic [31:0] branch_imm,
  input  logic [25:0] jump_target,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  logic [31:0] branch_off;

  assign pc_plus4   = pc + 32'd4;
  assign branch_off = branch_imm << 2;

  always_comb begin
    next_pc = pc_plus4;
    if (Jump) begin
      next_pc = {pc_plus4[31:28], jump_target, 2'b00};
    end else if (Branch && Zero) begin
      next_pc = pc_plus4 + branch_off;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over a req/ack port and holds each
// instruction for the decoder until it retires, then steps the PC.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = ResetPc,
  parameter logic [31:0] NOP_INSTR = NopInstr
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        instr_ready,
  input  logic        Jump,
  input  logic        Branch,
  input  logic        Zero,
  input  logic [31:0] branch_imm,
  input  logic [25:0] jump_target,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         valid_q, valid_d;
  logic [31:0]  next_pc;

  next_pc_logic u_next_pc (
    .pc          (pc_q),
    .Jump        (Jump),
    .Branch      (Branch),
    .Zero        (Zero),
    .branch_imm  (branch_imm),
    .jump_target (jump_target),
    .pc_plus4    (pc_plus4),
    .next_pc     (next_pc)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    imem_req = 1'b0;
    unique case (state_q)
      // Guarantees one idle cycle after reset; a stale ack here is dropped.
      StBoot: state_d = StReq;
      StReq: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          state_d = StHold;
        end
      end
      StHold: begin
        if (instr_ready) begin
          pc_d    = next_pc;
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          state_d = StReq;
        end
      end
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;

endmodule
